// File: rtl/instr_fetch_queue.sv
// Instruction prefetch queue: sequential word fetch over a req/ack memory port into a PC-tagged
// DEPTH-entry buffer, with redirect flush. Define IFQ_BYPASS_EN to forward an ack to an empty head.
module instr_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     start_i,
    input  logic                     redirect_i,
    input  logic [31:0]              redirect_pc_i,
    output logic                     imem_req_o,
    output logic [31:0]              imem_addr_o,
    input  logic                     imem_ack_i,
    input  logic [31:0]              imem_data_i,
    output logic                     instr_valid_o,
    output logic [31:0]              instr_o,
    output logic [31:0]              instr_pc_o,
    input  logic                     instr_ready_i,
    output logic [$clog2(DEPTH):0]   level_o
);
    localparam int unsigned PW  = $clog2(DEPTH);
    localparam int unsigned CW  = $clog2(DEPTH) + 1;
    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {StIdle, StReq, StDrain} state_t;

    state_t        state, state_nxt;
    logic [31:0]   fetch_pc, fetch_pc_nxt;
    logic          req_valid, req_valid_nxt;
    logic [31:0]   req_addr, req_addr_nxt;
    logic [PW-1:0] head, tail;
    logic [CW-1:0] count, count_nxt;
    logic [31:0]   pc_mem   [DEPTH];
    logic [31:0]   data_mem [DEPTH];
    logic          head_valid, ack_req, bypass_take, push, pop, can_issue;
    logic [31:0]   target_pc;
    logic          unused_pc_bits;

    assign target_pc      = {redirect_pc_i[31:2], 2'b00};
    assign unused_pc_bits = ^redirect_pc_i[1:0];
    assign head_valid     = (count != '0);
    assign ack_req        = (state == StReq) && imem_ack_i;

`ifdef IFQ_BYPASS_EN
    logic bypass_hit;
    assign bypass_hit    = !head_valid && ack_req && !redirect_i;
    assign bypass_take   = bypass_hit && instr_ready_i;
    assign instr_valid_o = head_valid || bypass_hit;

    always_comb begin
        if (head_valid) begin
            instr_o    = data_mem[head];
            instr_pc_o = pc_mem[head];
        end else if (bypass_hit) begin
            instr_o    = imem_data_i;
            instr_pc_o = req_addr;
        end else begin
            instr_o    = NOP;
            instr_pc_o = '0;
        end
    end
`else
    assign bypass_take   = 1'b0;
    assign instr_valid_o = head_valid;
    assign instr_o       = head_valid ? data_mem[head] : NOP;
    assign instr_pc_o    = head_valid ? pc_mem[head] : '0;
`endif

    // Redirect wins over push and pop; a drained ack is never pushed.
    assign push = ack_req && !redirect_i && !bypass_take;
    assign pop  = head_valid && instr_ready_i && !redirect_i;

    assign imem_req_o  = req_valid;
    assign imem_addr_o = req_addr;
    assign level_o     = count;

    always_comb begin
        state_nxt     = state;
        req_valid_nxt = req_valid;
        req_addr_nxt  = req_addr;
        fetch_pc_nxt  = fetch_pc;
        count_nxt     = redirect_i ? '0 : count + CW'(push) - CW'(pop);
        // Evaluated on post-edge occupancy, with no request outstanding after this edge.
        can_issue     = start_i && (count_nxt < CW'(DEPTH));

        if (redirect_i) begin
            fetch_pc_nxt = target_pc;
        end else if (ack_req) begin
            fetch_pc_nxt = fetch_pc + 32'd4;
        end

        unique case (state)
            StIdle: begin
                if (can_issue) begin
                    state_nxt     = StReq;
                    req_valid_nxt = 1'b1;
                    req_addr_nxt  = fetch_pc_nxt;
                end
            end
            StReq, StDrain: begin
                if (imem_ack_i) begin
                    if (can_issue) begin
                        state_nxt     = StReq;
                        req_valid_nxt = 1'b1;
                        req_addr_nxt  = fetch_pc_nxt;
                    end else begin
                        state_nxt     = StIdle;
                        req_valid_nxt = 1'b0;
                    end
                end else if (redirect_i) begin
                    state_nxt = StDrain;
                end
            end
            default: begin
                state_nxt     = StIdle;
                req_valid_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= StIdle;
            fetch_pc  <= RESET_PC;
            req_valid <= 1'b0;
            req_addr  <= RESET_PC;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
        end else begin
            state     <= state_nxt;
            fetch_pc  <= fetch_pc_nxt;
            req_valid <= req_valid_nxt;
            req_addr  <= req_addr_nxt;
            count     <= count_nxt;
            if (redirect_i) begin
                head <= '0;
                tail <= '0;
            end else begin
                if (push) tail <= tail + PW'(1);
                if (pop)  head <= head + PW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            pc_mem[tail]   <= req_addr;
            data_mem[tail] <= imem_data_i;
        end
    end

    // The outstanding request always holds a reserved slot.
    assert property (@(posedge clk_i) disable iff (rst_i)
        push |-> ((count < CW'(DEPTH)) || pop));

    assert property (@(posedge clk_i) disable iff (rst_i)
        (req_valid && !imem_ack_i) |=> (req_valid && $stable(req_addr)));

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: variable-latency memory responder plus a queue scoreboard of
// expected {pc, word} pairs checked as the consumer pops them.
module tb_instr_fetch_queue;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        start_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        imem_req_o;
    logic [31:0] imem_addr_o;
    logic        imem_ack_i = 1'b0;
    logic [31:0] imem_data_i = '0;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i = 1'b0;
    logic [$clog2(DEPTH):0] level_o;

    instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .start_i       (start_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .imem_req_o    (imem_req_o),
        .imem_addr_o   (imem_addr_o),
        .imem_ack_i    (imem_ack_i),
        .imem_data_i   (imem_data_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_ready_i (instr_ready_i),
        .level_o       (level_o)
    );

    always #5 clk_i = ~clk_i;

    int          n_vec = 0;
    int          n_miss = 0;
    logic [31:0] sb_pc[$];
    logic [31:0] sb_data[$];
    logic [31:0] req_log[$];
    int          lat = 1;
    int          wait_cnt = 0;
    int          max_level = 0;
    bit          do_redirect = 0;
    logic [31:0] redir_target = '0;
    bit          draining = 0;
    bit          prev_req = 0;
    bit          prev_ack = 0;
    logic [31:0] cur_addr = '0;
    logic [31:0] exp_pc = '0;

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return (a * 32'd3) ^ 32'hC0DE_0000;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        start_i = 1'b0;
        redirect_i = 1'b0;
        imem_ack_i = 1'b0;
        instr_ready_i = 1'b0;
        sb_pc.delete();
        sb_data.delete();
        req_log.delete();
        draining = 0;
        prev_req = 0;
        prev_ack = 0;
        wait_cnt = 0;
        exp_pc = '0;
        max_level = 0;
        do_redirect = 0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
    endtask

    // One clock cycle: called at posedge+1, returns at the next posedge+1.
    task automatic step();
        bit          new_req, ack, discard, byp, exp_valid, took_byp;
        logic [31:0] d, hp, hd;
        new_req = imem_req_o && (!prev_req || prev_ack);
        if (new_req) begin
            wait_cnt = 0;
            cur_addr = imem_addr_o;
            check_eq("req_addr", imem_addr_o, exp_pc);
            req_log.push_back(imem_addr_o);
        end else if (imem_req_o) begin
            check_eq("addr_hold", imem_addr_o, cur_addr);
        end
        ack = imem_req_o && (wait_cnt == lat);
        d = ack ? data_of(cur_addr) : 32'hBAD0_0000 + 32'(wait_cnt);
        imem_ack_i    = ack;
        imem_data_i   = d;
        redirect_i    = do_redirect;
        redirect_pc_i = redir_target;
        @(negedge clk_i);
        discard = draining || do_redirect;
        byp = 0;
`ifdef IFQ_BYPASS_EN
        byp = (sb_pc.size() == 0) && ack && !discard;
`endif
        if (int'(level_o) > max_level) max_level = int'(level_o);
        check_eq("level", 32'(level_o), 32'(sb_pc.size()));
        exp_valid = (sb_pc.size() != 0) || byp;
        check_eq("valid", 32'(instr_valid_o), 32'(exp_valid));
        took_byp = 0;
        if (exp_valid) begin
            hp = (sb_pc.size() != 0) ? sb_pc[0] : cur_addr;
            hd = (sb_pc.size() != 0) ? sb_data[0] : d;
            check_eq("head_pc", instr_pc_o, hp);
            check_eq("head_instr", instr_o, hd);
            if (instr_ready_i && !do_redirect) begin
                if (sb_pc.size() != 0) begin
                    void'(sb_pc.pop_front());
                    void'(sb_data.pop_front());
                end else begin
                    took_byp = 1;
                end
            end
        end else begin
            check_eq("nop", instr_o, NOP);
        end
        if (ack && !discard && !took_byp) begin
            sb_pc.push_back(cur_addr);
            sb_data.push_back(d);
        end
        if (do_redirect) begin
            sb_pc.delete();
            sb_data.delete();
            exp_pc = {redir_target[31:2], 2'b00};
            draining = imem_req_o && !ack;
        end else if (ack) begin
            if (!draining) exp_pc = cur_addr + 32'd4;
            draining = 0;
        end
        prev_req = imem_req_o;
        prev_ack = ack;
        if (imem_req_o && !ack) wait_cnt++;
        do_redirect = 0;
        @(posedge clk_i);
        #1;
        imem_ack_i = 1'b0;
        redirect_i = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int base;
        do_reset();
        check_eq("rst_req", 32'(imem_req_o), 32'd0);
        check_eq("rst_addr", imem_addr_o, 32'h0);
        check_eq("rst_valid", 32'(instr_valid_o), 32'd0);
        check_eq("rst_instr", instr_o, NOP);
        check_eq("rst_pc", instr_pc_o, 32'h0);
        check_eq("rst_level", 32'(level_o), 32'd0);

        // Sequential fetch, one-cycle ack latency, consumer always ready.
        start_i = 1'b1;
        instr_ready_i = 1'b1;
        lat = 1;
        repeat (20) step();
        check_eq("seq_n", 32'(req_log.size() >= 3), 32'd1);
        if (req_log.size() >= 3) begin
            check_eq("seq_a0", req_log[0], 32'h0);
            check_eq("seq_a1", req_log[1], 32'h4);
            check_eq("seq_a2", req_log[2], 32'h8);
        end
        check_eq("seq_lvl_le1", 32'(max_level <= 1), 32'd1);

        // Stalled consumer fills the queue; one pop releases exactly one more request.
        do_reset();
        start_i = 1'b1;
        lat = 0;
        repeat (12) step();
        check_eq("full_reqs", 32'(req_log.size()), 32'd4);
        check_eq("full_level", 32'(level_o), 32'd4);
        check_eq("full_req_low", 32'(imem_req_o), 32'd0);
        instr_ready_i = 1'b1;
        step();
        instr_ready_i = 1'b0;
        repeat (6) step();
        check_eq("refill_reqs", 32'(req_log.size()), 32'd5);
        check_eq("refill_level", 32'(level_o), 32'd4);

        // Redirect while a slow request to 0x10 is pending.
        do_reset();
        start_i = 1'b1;
        instr_ready_i = 1'b1;
        lat = 3;
        n = 0;
        while (!(req_log.size() > 0 && req_log[req_log.size()-1] == 32'h10) && n < 100) begin
            step();
            n++;
        end
        check_eq("drain_reach", 32'(n < 100), 32'd1);
        step();
        do_redirect = 1;
        redir_target = 32'h0000_0103;
        step();
        base = req_log.size();
        n = 0;
        while (req_log.size() == base && n < 20) begin
            step();
            n++;
        end
        check_eq("drain_next", 32'(req_log.size() > base), 32'd1);
        if (req_log.size() > base) check_eq("drain_addr", req_log[base], 32'h100);
        repeat (10) step();

        // Redirect coinciding with an ack and a pop at level 2.
        do_reset();
        start_i = 1'b1;
        lat = 0;
        n = 0;
        while (level_o != 2 && n < 20) begin
            step();
            n++;
        end
        check_eq("co_reach", 32'(level_o), 32'd2);
        check_eq("co_req", 32'(imem_req_o), 32'd1);
        instr_ready_i = 1'b1;
        do_redirect = 1;
        redir_target = 32'h0000_0200;
        step();
        check_eq("co_level", 32'(level_o), 32'd0);
        check_eq("co_valid", 32'(instr_valid_o), 32'd0);
        repeat (8) step();

        // Fetch PC wrap at the top of the address space.
        do_reset();
        do_redirect = 1;
        redir_target = 32'hFFFF_FFFE;
        step();
        start_i = 1'b1;
        instr_ready_i = 1'b1;
        lat = 1;
        max_level = 0;
        repeat (8) step();
        check_eq("wrap_n", 32'(req_log.size() >= 2), 32'd1);
        if (req_log.size() >= 2) begin
            check_eq("wrap_a0", req_log[0], 32'hFFFF_FFFC);
            check_eq("wrap_a1", req_log[1], 32'h0);
        end
`ifdef IFQ_BYPASS_EN
        check_eq("bypass_lvl0", 32'(max_level), 32'd0);
`endif

        // Dropping start_i lets the outstanding request finish but issues nothing new.
        do_reset();
        start_i = 1'b1;
        lat = 2;
        n = 0;
        while (req_log.size() < 2 && n < 20) begin
            step();
            n++;
        end
        start_i = 1'b0;
        repeat (10) step();
        check_eq("stop_reqs", 32'(req_log.size()), 32'd2);
        check_eq("stop_level", 32'(level_o), 32'd2);

        // Asynchronous reset mid-request, then a stray ack.
        do_reset();
        start_i = 1'b1;
        instr_ready_i = 1'b1;
        lat = 5;
        repeat (3) step();
        check_eq("ar_pending", 32'(imem_req_o), 32'd1);
        rst_i = 1'b1;
        #1;
        check_eq("ar_req", 32'(imem_req_o), 32'd0);
        check_eq("ar_addr", imem_addr_o, 32'h0);
        check_eq("ar_level", 32'(level_o), 32'd0);
        do_reset();
        imem_ack_i = 1'b1;
        imem_data_i = 32'h1234_5678;
        @(posedge clk_i);
        #1 imem_ack_i = 1'b0;
        check_eq("stray_level", 32'(level_o), 32'd0);
        check_eq("stray_valid", 32'(instr_valid_o), 32'd0);
        check_eq("stray_req", 32'(imem_req_o), 32'd0);
        repeat (3) step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Instruction prefetch queue between the fetch stage and a handshaked, variable-latency instruction memory port.
- Issues sequential word fetches, buffers up to DEPTH instructions tagged with their PC, and presents the queue head to the IF/ID latch.
- On a jump or branch redirect: flushes all buffered and in-flight work, then restarts fetching at the new target.

Parameters:
DEPTH, 4, queue entries; power of two, 2..16
RESET_PC, 32'h00000000, first fetch address after reset

Ports:
clk_i  input  1  clock; all state changes on the rising edge
rst_i  input  1  asynchronous, active-high reset
start_i  input  1  fetch enable; no new request issues while low
redirect_i  input  1  flush and restart fetch; single-cycle pulse
redirect_pc_i  input  32  new fetch target; bits [1:0] are forced to 0
imem_req_o  output  1  memory request valid
imem_addr_o  output  32  word address of the request
imem_ack_i  input  1  request completed; imem_data_i is valid this cycle
imem_data_i  input  32  fetched instruction word
instr_valid_o  output  1  queue head is valid
instr_o  output  32  head instruction; 32'h00000013 (NOP) when invalid
instr_pc_o  output  32  PC of the head instruction
instr_ready_i  input  1  consumer pops the head this cycle (0 = pipeline stall)
level_o  output  $clog2(DEPTH)+1  number of valid entries

Behaviour:
- Reset values: fetch_pc = RESET_PC; queue empty; state IDLE; imem_req_o = 0; imem_addr_o = RESET_PC; instr_valid_o = 0; instr_o = NOP; instr_pc_o = 0; level_o = 0.
- State IDLE:
  - Issue a request when start_i = 1 and level + outstanding < DEPTH.
  - Issuing sets imem_req_o = 1 and imem_addr_o = fetch_pc on the next edge, then moves to REQ.
- State REQ:
  - imem_req_o and imem_addr_o are held stable until imem_ack_i = 1.
  - At most one request is outstanding.
  - On ack: push {fetch_pc, imem_data_i} and set fetch_pc += 4, wrapping 32'hFFFFFFFC -> 0.
  - On the ack edge, if the issue condition still holds, issue back-to-back: imem_req_o stays 1 with the new address and the state stays REQ. Otherwise go to IDLE with req = 0.
- State DRAIN:
  - Entered on a redirect while REQ is active and there is no ack in the same cycle.
  - imem_req_o stays high until the ack. The acked data is discarded and not pushed.
  - Then issue at the redirect target.
- Slot reservation: the outstanding request counts against DEPTH, so a push never overflows.
  - Push and pop in the same cycle at full: both occur and level is unchanged.
- Pop: on instr_valid_o & instr_ready_i the head is removed. The new head is visible after the edge.
  - Pop on an empty queue is ignored.
- Redirect priority: redirect > ack/push > pop.
  - The redirect edge empties the queue, so instr_valid_o = 0 on the next cycle.
  - fetch_pc is set to {redirect_pc_i[31:2], 2'b00}.
  - If REQ is active with no ack, go to DRAIN. If the ack coincides with the redirect, discard the data and go straight to IDLE/issue.
  - A redirect while in DRAIN overwrites the target and stays in DRAIN.
- Latency: queue empty, no bypass, request issued at edge N, ack in cycle N+k -> instr_valid_o high in cycle N+k+1.
- start_i falling: the outstanding request completes and is pushed; no further issues.
- Asynchronous reset mid-request: all state clears immediately. Any later stray ack is ignored because the state is IDLE.

Optional Feature:
- Macro: IFQ_BYPASS_EN.
- Defined: when the queue is empty, the state is REQ (not DRAIN), imem_ack_i = 1 and redirect_i = 0:
  - instr_valid_o = 1, instr_o = imem_data_i and instr_pc_o = imem_addr_o combinationally in the same cycle.
  - If instr_ready_i = 1 the word is consumed and not pushed; otherwise it is pushed normally.
  - Saves one cycle of fetch latency.
- Undefined: outputs come only from queue registers; no combinational path from the imem inputs to the outputs.

Test Plan:
- Reset release, start_i = 1, ack 1 cycle after each req, ready = 1 -> addresses 0, 4, 8 in order; instr_pc_o matches each word; level_o <= 1.
- ready_i = 0, immediate acks, DEPTH = 4 -> exactly 4 requests; level_o = 4; imem_req_o = 0 until the first pop, then one more request.
- Redirect to 32'h00000103 while a request to 0x10 waits 3 cycles for ack -> 0x10 data dropped; next imem_addr_o = 32'h00000100; instr_valid_o = 0 until 0x100 arrives.
- Redirect in the same cycle as the ack and a pop, with level = 2 -> level_o = 0 next cycle; the acked word is never presented.
- fetch_pc = 32'hFFFFFFFC, ack -> next request address 0; with IFQ_BYPASS_EN, empty queue and ready = 1 -> instr_valid_o high in the ack cycle and level_o stays 0.
